// File: rtl/tausworthe_checker.sv
// Checks a stream of taus88 words against an internal reference generator and tracks lock/fail status.
// Optional first-mismatch capture outputs are enabled by defining TAUS_CHK_CAPTURE_EN.
module tausworthe_checker (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [31:0] random_in,
  input  logic        valid_in,
  input  logic        clear,
  output logic        match_valid,
  output logic        match,
  output logic        locked,
  output logic        fail,
  output logic [15:0] error_count,
  output logic [31:0] beat_count
`ifdef TAUS_CHK_CAPTURE_EN
  ,
  output logic [31:0] first_bad_exp,
  output logic [31:0] first_bad_got,
  output logic [31:0] first_bad_beat
`endif
);

  localparam logic [31:0] SEED0 = 32'h0f0f_0f0f;
  localparam logic [31:0] SEED1 = 32'h0c0c_0c0c;
  localparam logic [31:0] SEED2 = 32'h00ff_00ff;

  typedef enum logic [1:0] {ST_IDLE, ST_CHECKING, ST_LOCKED, ST_FAIL} state_t;

  function automatic logic [31:0] step0(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 13) ^ s) >> 19;
    return ((s & 32'hffff_fffe) << 12) ^ b;
  endfunction

  function automatic logic [31:0] step1(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 2) ^ s) >> 25;
    return ((s & 32'hffff_fff8) << 4) ^ b;
  endfunction

  function automatic logic [31:0] step2(input logic [31:0] s);
    logic [31:0] b;
    b = ((s << 3) ^ s) >> 11;
    return ((s & 32'hffff_fff0) << 17) ^ b;
  endfunction

  state_t      state_q, state_d;
  logic [31:0] s0_q, s0_d, s1_q, s1_d, s2_q, s2_d;
  logic [4:0]  streak_q, streak_d;
  logic [15:0] err_q, err_d;
  logic [31:0] beats_q, beats_d;
  logic        mv_q, mv_d, match_q, match_d, locked_q, locked_d, fail_q, fail_d;
  logic [31:0] s0_n, s1_n, s2_n, exp_w;
  logic        hit;
`ifdef TAUS_CHK_CAPTURE_EN
  logic [31:0] fb_exp_q, fb_exp_d, fb_got_q, fb_got_d, fb_beat_q, fb_beat_d;
`endif

  // The expected word comes from the advanced state, so the first beat checks step-1 output.
  assign s0_n  = step0(s0_q);
  assign s1_n  = step1(s1_q);
  assign s2_n  = step2(s2_q);
  assign exp_w = s0_n ^ s1_n ^ s2_n;
  assign hit   = (random_in == exp_w);

  always_comb begin
    state_d  = state_q;
    s0_d     = s0_q;
    s1_d     = s1_q;
    s2_d     = s2_q;
    streak_d = streak_q;
    err_d    = err_q;
    beats_d  = beats_q;
    mv_d     = 1'b0;
    match_d  = 1'b0;
`ifdef TAUS_CHK_CAPTURE_EN
    fb_exp_d  = fb_exp_q;
    fb_got_d  = fb_got_q;
    fb_beat_d = fb_beat_q;
`endif
    if (clear) begin
      state_d  = ST_IDLE;
      s0_d     = SEED0;
      s1_d     = SEED1;
      s2_d     = SEED2;
      streak_d = 5'd0;
      err_d    = 16'd0;
      beats_d  = 32'd0;
`ifdef TAUS_CHK_CAPTURE_EN
      fb_exp_d  = 32'd0;
      fb_got_d  = 32'd0;
      fb_beat_d = 32'd0;
`endif
    end else if (valid_in) begin
      s0_d    = s0_n;
      s1_d    = s1_n;
      s2_d    = s2_n;
      mv_d    = 1'b1;
      match_d = hit;
      beats_d = beats_q + 32'd1;
      if (!hit && err_q != 16'hffff) err_d = err_q + 16'd1;
`ifdef TAUS_CHK_CAPTURE_EN
      // error_count never returns to zero until clear/reset, so zero marks "no mismatch yet".
      if (!hit && err_q == 16'd0) begin
        fb_exp_d  = exp_w;
        fb_got_d  = random_in;
        fb_beat_d = beats_q;
      end
`endif
      case (state_q)
        ST_IDLE: begin
          state_d  = ST_CHECKING;
          streak_d = hit ? 5'd1 : 5'd0;
        end
        ST_CHECKING: begin
          if (!hit) begin
            streak_d = 5'd0;
          end else if (streak_q == 5'd15) begin
            streak_d = 5'd16;
            state_d  = ST_LOCKED;
          end else begin
            streak_d = streak_q + 5'd1;
          end
        end
        ST_LOCKED: if (!hit) state_d = ST_FAIL;
        default:   state_d = ST_FAIL;
      endcase
    end
    locked_d = (state_d == ST_LOCKED);
    fail_d   = (state_d == ST_FAIL);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      s0_q     <= SEED0;
      s1_q     <= SEED1;
      s2_q     <= SEED2;
      streak_q <= 5'd0;
      err_q    <= 16'd0;
      beats_q  <= 32'd0;
      mv_q     <= 1'b0;
      match_q  <= 1'b0;
      locked_q <= 1'b0;
      fail_q   <= 1'b0;
`ifdef TAUS_CHK_CAPTURE_EN
      fb_exp_q  <= 32'd0;
      fb_got_q  <= 32'd0;
      fb_beat_q <= 32'd0;
`endif
    end else begin
      state_q  <= state_d;
      s0_q     <= s0_d;
      s1_q     <= s1_d;
      s2_q     <= s2_d;
      streak_q <= streak_d;
      err_q    <= err_d;
      beats_q  <= beats_d;
      mv_q     <= mv_d;
      match_q  <= match_d;
      locked_q <= locked_d;
      fail_q   <= fail_d;
`ifdef TAUS_CHK_CAPTURE_EN
      fb_exp_q  <= fb_exp_d;
      fb_got_q  <= fb_got_d;
      fb_beat_q <= fb_beat_d;
`endif
    end
  end

  assign match_valid = mv_q;
  assign match       = match_q;
  assign locked      = locked_q;
  assign fail        = fail_q;
  assign error_count = err_q;
  assign beat_count  = beats_q;
`ifdef TAUS_CHK_CAPTURE_EN
  assign first_bad_exp  = fb_exp_q;
  assign first_bad_got  = fb_got_q;
  assign first_bad_beat = fb_beat_q;
`endif

endmodule

// File: tb/tb_tausworthe_checker.sv
// Randomized self-checking bench for tausworthe_checker against a behavioural taus88 reference model.
// Define TAUS_CHK_CAPTURE_EN to also check the first-mismatch capture outputs.
module tb_tausworthe_checker;

  localparam logic [95:0] SEEDS = {32'h0f0f0f0f, 32'h0c0c0c0c, 32'h00ff00ff};

  logic        clk = 1'b0;
  logic        reset_n = 1'b1;
  logic [31:0] random_in = 32'd0;
  logic        valid_in = 1'b0;
  logic        clear = 1'b0;
  logic        match_valid, match, locked, fail;
  logic [15:0] error_count;
  logic [31:0] beat_count;
`ifdef TAUS_CHK_CAPTURE_EN
  logic [31:0] first_bad_exp, first_bad_got, first_bad_beat;
`endif

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  tausworthe_checker dut (
    .clock(clk), .reset_n(reset_n), .random_in(random_in), .valid_in(valid_in), .clear(clear),
    .match_valid(match_valid), .match(match), .locked(locked), .fail(fail),
    .error_count(error_count), .beat_count(beat_count)
`ifdef TAUS_CHK_CAPTURE_EN
    , .first_bad_exp(first_bad_exp), .first_bad_got(first_bad_got), .first_bad_beat(first_bad_beat)
`endif
  );

  // Reference model: generator state for stimulus, checker state for expectations.
  logic [95:0] g_st, m_st;
  int          m_streak, m_err;
  bit          m_locked, m_failed, m_match, m_have_bad;
  logic [31:0] m_beats, m_fb_exp, m_fb_got, m_fb_beat;

  function automatic logic [95:0] taus_adv(input logic [95:0] st);
    logic [31:0] a, b, c;
    a = st[95:64]; b = st[63:32]; c = st[31:0];
    a = ((a & 32'hfffffffe) << 12) ^ (((a << 13) ^ a) >> 19);
    b = ((b & 32'hfffffff8) << 4)  ^ (((b << 2) ^ b) >> 25);
    c = ((c & 32'hfffffff0) << 17) ^ (((c << 3) ^ c) >> 11);
    return {a, b, c};
  endfunction

  function automatic logic [31:0] taus_out(input logic [95:0] st);
    return st[95:64] ^ st[63:32] ^ st[31:0];
  endfunction

  task automatic model_reset();
    g_st = SEEDS; m_st = SEEDS;
    m_streak = 0; m_err = 0; m_beats = 32'd0;
    m_locked = 0; m_failed = 0; m_match = 0; m_have_bad = 0;
    m_fb_exp = 32'd0; m_fb_got = 32'd0; m_fb_beat = 32'd0;
  endtask

  task automatic model_accept(input logic [31:0] got);
    logic [31:0] e;
    m_st = taus_adv(m_st);
    e = taus_out(m_st);
    m_match = (got == e);
    if (!m_match && !m_have_bad) begin
      m_have_bad = 1; m_fb_exp = e; m_fb_got = got; m_fb_beat = m_beats;
    end
    if (!m_match && m_err < 65535) m_err++;
    m_beats++;
    if (!m_locked && !m_failed) begin
      m_streak = m_match ? m_streak + 1 : 0;
      if (m_streak >= 16) m_locked = 1;
    end else if (m_locked && !m_match) begin
      m_locked = 0; m_failed = 1;
    end
  endtask

  task automatic gen_word(output logic [31:0] w);
    g_st = taus_adv(g_st);
    w = taus_out(g_st);
  endtask

  task automatic drive(input logic [31:0] w, input bit v, input bit c);
    @(negedge clk);
    random_in = w; valid_in = v; clear = c;
    @(posedge clk);
    #1;
    valid_in = 1'b0; clear = 1'b0;
  endtask

  task automatic beat(input bit corrupt);
    logic [31:0] w;
    gen_word(w);
    if (corrupt) w = w ^ 32'd1;
    drive(w, 1'b1, 1'b0);
    model_accept(w);
  endtask

  task automatic do_clear();
    drive($urandom, 1'b0, 1'b1);
    model_reset();
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    #23;
    model_reset();
    total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL reset_mv got=%b exp=0", match_valid); end
    total++; if (match !== 1'b0) begin bad++; $display("FAIL reset_match got=%b exp=0", match); end
    total++; if (locked !== 1'b0) begin bad++; $display("FAIL reset_locked got=%b exp=0", locked); end
    total++; if (fail !== 1'b0) begin bad++; $display("FAIL reset_fail got=%b exp=0", fail); end
    total++; if (error_count !== 16'd0) begin bad++; $display("FAIL reset_err got=%h exp=0", error_count); end
    total++; if (beat_count !== 32'd0) begin bad++; $display("FAIL reset_beats got=%h exp=0", beat_count); end
`ifdef TAUS_CHK_CAPTURE_EN
    total++; if ({first_bad_exp, first_bad_got, first_bad_beat} !== 96'd0) begin bad++;
      $display("FAIL reset_capture got=%h/%h/%h exp=0", first_bad_exp, first_bad_got, first_bad_beat); end
`endif
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  task automatic test_lock();
    for (int i = 1; i <= 20; i++) begin
      beat(1'b0);
      total++; if (match_valid !== 1'b1 || match !== 1'b1) begin bad++;
        $display("FAIL lock_match beat=%0d got=%b%b exp=11", i, match_valid, match); end
      total++; if (locked !== m_locked) begin bad++;
        $display("FAIL lock_locked beat=%0d got=%b exp=%b", i, locked, m_locked); end
    end
    total++; if (locked !== 1'b1) begin bad++; $display("FAIL lock_final got=%b exp=1", locked); end
    total++; if (error_count !== 16'd0) begin bad++; $display("FAIL lock_err got=%0d exp=0", error_count); end
    total++; if (beat_count !== 32'd20) begin bad++; $display("FAIL lock_beats got=%0d exp=20", beat_count); end
  endtask

  task automatic test_fail();
    for (int i = 21; i <= 30; i++) begin
      beat(i == 25);
      total++; if (match !== m_match) begin bad++;
        $display("FAIL fail_match beat=%0d got=%b exp=%b", i, match, m_match); end
      total++; if (fail !== m_failed || locked !== m_locked) begin bad++;
        $display("FAIL fail_state beat=%0d got=%b%b exp=%b%b", i, fail, locked, m_failed, m_locked); end
      total++; if (error_count !== 16'(m_err)) begin bad++;
        $display("FAIL fail_err beat=%0d got=%0d exp=%0d", i, error_count, m_err); end
    end
    total++; if (fail !== 1'b1 || error_count !== 16'd1) begin bad++;
      $display("FAIL fail_final got=%b/%0d exp=1/1", fail, error_count); end
`ifdef TAUS_CHK_CAPTURE_EN
    total++; if (first_bad_beat !== 32'd24 || first_bad_got !== m_fb_got || first_bad_exp !== m_fb_exp) begin bad++;
      $display("FAIL fail_capture got=%h/%h/%0d exp=%h/%h/24", first_bad_exp, first_bad_got, first_bad_beat, m_fb_exp, m_fb_got); end
`endif
  endtask

  task automatic test_streak();
    do_clear();
    for (int i = 1; i <= 25; i++) begin
      beat(i == 5);
      total++; if (locked !== m_locked || fail !== 1'b0) begin bad++;
        $display("FAIL streak beat=%0d got=%b%b exp=%b0", i, locked, fail, m_locked); end
    end
    total++; if (error_count !== 16'd1) begin bad++; $display("FAIL streak_err got=%0d exp=1", error_count); end
  endtask

  task automatic test_gapped();
    do_clear();
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 1) == 1) begin
        beat(1'b0);
        total++; if (match_valid !== 1'b1 || match !== 1'b1) begin bad++;
          $display("FAIL gap_match cyc=%0d got=%b%b exp=11", n, match_valid, match); end
      end else begin
        drive($urandom, 1'b0, 1'b0);
        total++; if (match_valid !== 1'b0) begin bad++;
          $display("FAIL gap_idle cyc=%0d got=%b exp=0", n, match_valid); end
      end
      total++; if (locked !== m_locked) begin bad++;
        $display("FAIL gap_locked cyc=%0d got=%b exp=%b", n, locked, m_locked); end
    end
    total++; if (error_count !== 16'd0 || beat_count !== m_beats) begin bad++;
      $display("FAIL gap_counts got=%0d/%0d exp=0/%0d", error_count, beat_count, m_beats); end
  endtask

  task automatic test_clear_in_fail();
    logic [31:0] w;
    do_clear();
    for (int i = 0; i < 16; i++) beat(1'b0);
    beat(1'b1);
    total++; if (fail !== 1'b1) begin bad++; $display("FAIL cf_enter got=%b exp=1", fail); end
    gen_word(w);
    drive(w, 1'b1, 1'b1);
    model_reset();
    total++; if ({match_valid, locked, fail} !== 3'b000) begin bad++;
      $display("FAIL cf_flags got=%b exp=000", {match_valid, locked, fail}); end
    total++; if (error_count !== 16'd0 || beat_count !== 32'd0) begin bad++;
      $display("FAIL cf_counts got=%0d/%0d exp=0/0", error_count, beat_count); end
`ifdef TAUS_CHK_CAPTURE_EN
    total++; if ({first_bad_exp, first_bad_got, first_bad_beat} !== 96'd0) begin bad++;
      $display("FAIL cf_capture got=%h/%h/%h exp=0", first_bad_exp, first_bad_got, first_bad_beat); end
`endif
    beat(1'b0);
    total++; if (match_valid !== 1'b1 || match !== 1'b1 || beat_count !== 32'd1) begin bad++;
      $display("FAIL cf_step1 got=%b%b/%0d exp=11/1", match_valid, match, beat_count); end
  endtask

  task automatic test_reset_midstream();
    logic [31:0] w;
    for (int i = 0; i < 5; i++) beat(1'b0);
    gen_word(w);
    @(negedge clk);
    random_in = w; valid_in = 1'b1;
    #2 reset_n = 1'b0;
    #1;
    total++; if (match_valid !== 1'b0 || beat_count !== 32'd0 || error_count !== 16'd0) begin bad++;
      $display("FAIL mid_async got=%b/%0d/%0d exp=0/0/0", match_valid, beat_count, error_count); end
    @(negedge clk);
    valid_in = 1'b0; reset_n = 1'b1;
    model_reset();
    @(posedge clk); #1;
    total++; if (match_valid !== 1'b0) begin bad++; $display("FAIL mid_release got=%b exp=0", match_valid); end
    beat(1'b0);
    total++; if (match !== 1'b1 || beat_count !== 32'd1) begin bad++;
      $display("FAIL mid_step1 got=%b/%0d exp=1/1", match, beat_count); end
  endtask

  task automatic test_saturate();
    do_clear();
    for (int i = 0; i < 70000; i++) begin
      drive(32'd0, 1'b1, 1'b0);
      model_accept(32'd0);
    end
    total++; if (error_count !== 16'(m_err) || error_count !== 16'hffff) begin bad++;
      $display("FAIL sat_err got=%h exp=%h", error_count, 16'(m_err)); end
    total++; if (beat_count !== 32'd70000) begin bad++; $display("FAIL sat_beats got=%0d exp=70000", beat_count); end
`ifdef TAUS_CHK_CAPTURE_EN
    total++; if (first_bad_beat !== 32'd0 || first_bad_got !== 32'd0 || first_bad_exp !== m_fb_exp) begin bad++;
      $display("FAIL sat_capture got=%h/%h/%0d exp=%h/0/0", first_bad_exp, first_bad_got, first_bad_beat, m_fb_exp); end
`endif
  endtask

  initial begin
    test_reset();
    test_lock();
    test_fail();
    test_streak();
    test_gapped();
    test_clear_in_fail();
    test_reset_midstream();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tausworthe_checker.md
TAUSWORTHE_CHECKER -- requirements
Module: tausworthe_checker

Interface
REQ-001 SHALL have port: clock  input  1  sole clock, rising edge.
REQ-002 SHALL have port: reset_n  input  1  asynchronous, active-low reset.
REQ-003 SHALL have port: random_in  input  32  uniform word from the three-component Tausworthe (taus88) generator under test.
REQ-004 SHALL have port: valid_in  input  1  random_in valid this cycle; no backpressure, every valid beat is consumed.
REQ-005 SHALL have port: clear  input  1  synchronous restart of checker state and counters.
REQ-006 SHALL have port: match_valid  output  1  compare result valid, one cycle after an accepted beat.
REQ-007 SHALL have port: match  output  1  received word equalled expected word; qualified by match_valid.
REQ-008 SHALL have port: locked  output  1  state is LOCKED.
REQ-009 SHALL have port: fail  output  1  state is FAIL; sticky.
REQ-010 SHALL have port: error_count  output  16  mismatch count, saturating.
REQ-011 SHALL have port: beat_count  output  32  accepted-beat count, wraps.

Function
REQ-012 SHALL hold reference state S0, S1, S2, 32 bits each, with seeds S0=0x0f0f0f0f, S1=0x0c0c0c0c, S2=0x00ff00ff.
REQ-013 SHALL advance state only on an accepted beat: b1=((S0<<13)^S0)>>19, S0'=((S0&0xfffffffe)<<12)^b1; b2=((S1<<2)^S1)>>25, S1'=((S1&0xfffffff8)<<4)^b2; b3=((S2<<3)^S2)>>11, S2'=((S2&0xfffffff0)<<17)^b3; all logical shifts, truncated to 32 bits.
REQ-014 SHALL compare each accepted beat's random_in against expected word S0'^S1'^S2', i.e. XOR of the advanced state, so the first valid beat after reset is checked against step-1 output, not the seeds.
REQ-015 SHALL register compare results: match_valid=1 and match set in the cycle after the beat; match_valid=0 otherwise.
REQ-016 SHALL implement FSM IDLE, CHECKING, LOCKED, FAIL.
REQ-017 SHALL transition IDLE->CHECKING on first accepted beat; that beat is compared and counted.
REQ-018 SHALL keep a 5-bit consecutive-match streak; CHECKING->LOCKED when the streak reaches 16; a mismatch in CHECKING zeroes the streak and stays in CHECKING.
REQ-019 SHALL transition LOCKED->FAIL on any mismatch; FAIL is left only by clear or reset.
REQ-020 SHALL increment error_count on every mismatch in any state, saturating at 0xFFFF.
REQ-021 SHALL increment beat_count on every accepted beat in any state, wrapping 0xFFFFFFFF->0.
REQ-022 SHALL, in FAIL, continue advancing state and counting so later beats remain aligned.
REQ-023 SHALL, on clear=1, reload seeds, zero streak and counters, go to IDLE, and drive match_valid=0 next cycle; clear takes priority over a simultaneous valid_in, and that beat is dropped uncounted.
REQ-024 SHALL drive locked and fail as registered decodes of state.

Reset
REQ-025 SHALL, while reset_n=0, asynchronously load seeds, state=IDLE, streak=0, and all outputs 0 (match_valid, match, locked, fail, error_count, beat_count).
REQ-026 SHALL, on reset assertion mid-stream, abandon the in-flight compare; match_valid is 0 in the first cycle after release.

Configuration
REQ-027 SHALL, with TAUS_CHK_CAPTURE_EN defined, add outputs first_bad_exp[31:0], first_bad_got[31:0], first_bad_beat[31:0], capturing expected word, received word and beat_count value (pre-increment) of the first mismatch since reset/clear; later mismatches do not overwrite; cleared to 0 by reset and clear.
REQ-028 SHALL, without TAUS_CHK_CAPTURE_EN, omit those ports and registers; all other behaviour is identical.

Verification
REQ-029 SHALL cover: reset, then 20 beats from a matching taus88 model -> match=1 each beat, locked=1 the cycle after beat 16, error_count=0, beat_count=20.
REQ-030 SHALL cover: LOCKED, beat 25 corrupted (bit 0 flipped) -> match=0, fail=1 next cycle, error_count=1, later correct beats give match=1, fail stays 1.
REQ-031 SHALL cover: beat 5 corrupted in CHECKING -> streak resets, locked asserts only after beat 21, fail=0.
REQ-032 SHALL cover: valid_in gapped randomly (50% duty) -> results identical to back-to-back, no false mismatches.
REQ-033 SHALL cover: clear asserted together with valid_in in FAIL -> beat dropped, next cycle state=IDLE, counts 0, match_valid=0; next beat checked against step-1 word.
REQ-034 SHALL cover: 70000 all-zero words -> error_count saturates at 0xFFFF, beat_count=70000; with TAUS_CHK_CAPTURE_EN, first_bad_beat=0 and first_bad_got=0.
